// File: rtl/ivt_pkg.sv
// Shared types and helpers for the interrupt vector responder.
// Build option: define IVT_WRITE_EN to make the vector table writable.
package ivt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } ivt_state_e;

  // Write size encodings, in bytes.
  localparam logic [7:0] SZ_B = 8'd1;
  localparam logic [7:0] SZ_H = 8'd2;
  localparam logic [7:0] SZ_W = 8'd4;

  function automatic logic ivt_size_ok(input logic [7:0] size);
    return (size == SZ_B) || (size == SZ_H) || (size == SZ_W);
  endfunction

  // Low-byte-aligned write data merged over the old entry; unknown sizes keep it.
  function automatic logic [31:0] ivt_merge(input logic [31:0] old_val,
                                            input logic [31:0] data,
                                            input logic [7:0]  size);
    logic [31:0] res;
    res = old_val;
    case (size)
      SZ_B:    res = {old_val[31:8], data[7:0]};
      SZ_H:    res = {old_val[31:16], data[15:0]};
      SZ_W:    res = data;
      default: res = old_val;
    endcase
    return res;
  endfunction

  // Reset value of entry idx: base plus idx strides.
  function automatic logic [31:0] ivt_reset_val(input logic [31:0] base,
                                                input logic [31:0] stride,
                                                input logic [31:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/interrupt_vector_responder_if.sv
// Request and data-phase channels of the emem port.
// Both channels use valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; the source holds its payload stable while
// valid is high and ready is low, and ready may be high before valid.
interface interrupt_vector_responder_if;
  logic        emem_valid;
  logic        emem_ready;
  logic [31:0] emem_address;
  logic        emem_wr_en;
  logic [31:0] emem_wr_data;
  logic [7:0]  emem_wr_size;
  logic        emem_dp_valid;
  logic        emem_dp_ready;
  logic [31:0] emem_dp_read_data;

  modport master (
    output emem_valid, emem_address, emem_wr_en, emem_wr_data, emem_wr_size,
    output emem_dp_ready,
    input  emem_ready, emem_dp_valid, emem_dp_read_data
  );

  modport slave (
    input  emem_valid, emem_address, emem_wr_en, emem_wr_data, emem_wr_size,
    input  emem_dp_ready,
    output emem_ready, emem_dp_valid, emem_dp_read_data
  );
endinterface

// File: rtl/ivt_table.sv
// Interrupt vector table: NUM_VEC x 32 entries, one full-word write port
// (data arrives already byte-merged) and a combinational read port.
// Build option: IVT_WRITE_EN builds the writable register array; otherwise
// the table is a constant function of the index.
module ivt_table
  import ivt_pkg::*;
#(
  parameter int          NUM_VEC    = 16,
  parameter int          IW         = 4,
  parameter logic [31:0] RESET_VEC  = 32'h0000_0400,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0008
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

`ifdef IVT_WRITE_EN
  logic [31:0] mem [NUM_VEC];

  // Entries return to their reset values on reset; one write per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        mem[i] <= ivt_reset_val(RESET_VEC, VEC_STRIDE, 32'(i));
      end
    end else if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
`else
  logic unused_wr;
  assign unused_wr = ^{clk, reset, we, wr_idx, wr_data};

  assign rd_data = (32'(rd_idx) < 32'(NUM_VEC)) ?
                   ivt_reset_val(RESET_VEC, VEC_STRIDE, 32'(rd_idx)) : 32'h0;
`endif

endmodule

// File: rtl/interrupt_vector_responder.sv
// emem responder: one outstanding request, answered with one data-phase
// beat after LATENCY cycles, served from the interrupt vector table.
// Build option: IVT_WRITE_EN enables table writes; without it writes are
// still accepted and answered with the current entry.
module interrupt_vector_responder
  import ivt_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          NUM_VEC    = 16,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] RESET_VEC  = 32'h0000_0400,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0008,
  parameter logic [31:0] MISS_DATA  = 32'h0000_0040
) (
  input  logic                          clk,
  input  logic                          reset,
  interrupt_vector_responder_if.slave   emem,
  output ivt_state_e                    dbg_state
);

  localparam int IW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

  ivt_state_e    state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [31:0]   rsp_data, rsp_nxt;
  logic [31:0]   offset;
  logic          in_range;
  logic          size_ok;
  logic [IW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   merged;
  logic [31:0]   hit_data;
  logic [31:0]   beat;
  logic          tbl_we;

  // Address decode: word index from BASE_ADDR, no wrap below the base.
  assign offset   = emem.emem_address - BASE_ADDR;
  assign in_range = (emem.emem_address >= BASE_ADDR) && ((offset >> 2) < 32'(NUM_VEC));
  assign idx      = offset[IW+1:2];
  assign size_ok  = ivt_size_ok(emem.emem_wr_size);
  assign merged   = ivt_merge(rd_word, emem.emem_wr_data, emem.emem_wr_size);
  assign tbl_we   = (state == ST_IDLE) && emem.emem_valid && emem.emem_wr_en &&
                    in_range && size_ok;

`ifdef IVT_WRITE_EN
  assign hit_data = (emem.emem_wr_en && size_ok) ? merged : rd_word;
`else
  assign hit_data = rd_word;
`endif
  assign beat = in_range ? hit_data : MISS_DATA;

  ivt_table #(
    .NUM_VEC    (NUM_VEC),
    .IW         (IW),
    .RESET_VEC  (RESET_VEC),
    .VEC_STRIDE (VEC_STRIDE)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .we      (tbl_we),
    .wr_idx  (idx),
    .wr_data (merged),
    .rd_idx  (idx),
    .rd_data (rd_word)
  );

  // State, latency counter and response word registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      rsp_data <= 32'h0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rsp_data <= rsp_nxt;
    end
  end

  // Next state: the beat is computed on the accept edge and held until taken.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rsp_nxt   = rsp_data;
    case (state)
      ST_IDLE: begin
        if (emem.emem_valid) begin
          rsp_nxt = beat;
          if (LATENCY > 1) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end else begin
            state_nxt = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = ST_RESP;
          cnt_nxt   = 4'd0;
        end
      end
      ST_RESP: begin
        if (emem.emem_dp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign emem.emem_ready        = (state == ST_IDLE);
  assign emem.emem_dp_valid     = (state == ST_RESP);
  assign emem.emem_dp_read_data = rsp_data;
  assign dbg_state              = state;

endmodule

// File: tb/tb_interrupt_vector_responder.sv
// Directed bench for interrupt_vector_responder: one instance at LATENCY=1
// and one at LATENCY=4, expected beats hand-computed per build option.
module tb_interrupt_vector_responder;
  import ivt_pkg::*;

`ifdef IVT_WRITE_EN
  localparam bit WR = 1'b1;
`else
  localparam bit WR = 1'b0;
`endif

  logic clk;
  logic reset;
  ivt_state_e dbg1, dbg4;

  interrupt_vector_responder_if if1 ();
  interrupt_vector_responder_if if4 ();

  interrupt_vector_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .emem(if1), .dbg_state(dbg1)
  );

  interrupt_vector_responder #(.LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .emem(if4), .dbg_state(dbg4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive(input int sel, input logic v, input logic [31:0] addr,
                       input logic wr, input logic [31:0] data, input logic [7:0] size);
    if (sel == 1) begin
      if1.emem_valid = v; if1.emem_address = addr; if1.emem_wr_en = wr;
      if1.emem_wr_data = data; if1.emem_wr_size = size;
    end else begin
      if4.emem_valid = v; if4.emem_address = addr; if4.emem_wr_en = wr;
      if4.emem_wr_data = data; if4.emem_wr_size = size;
    end
  endtask

  task automatic set_dp_ready(input int sel, input logic v);
    if (sel == 1) if1.emem_dp_ready = v;
    else          if4.emem_dp_ready = v;
  endtask

  function automatic logic [31:0] o_ready(input int sel);
    return (sel == 1) ? 32'(if1.emem_ready) : 32'(if4.emem_ready);
  endfunction
  function automatic logic [31:0] o_dpv(input int sel);
    return (sel == 1) ? 32'(if1.emem_dp_valid) : 32'(if4.emem_dp_valid);
  endfunction
  function automatic logic [31:0] o_data(input int sel);
    return (sel == 1) ? if1.emem_dp_read_data : if4.emem_dp_read_data;
  endfunction
  function automatic logic [31:0] o_state(input int sel);
    return (sel == 1) ? 32'(dbg1) : 32'(dbg4);
  endfunction

  // Wait (bounded) from the first sample after accept until dp_valid; k=1 is that first sample.
  task automatic wait_dpv(input int sel, output int k);
    k = 1;
    while (o_dpv(sel) == 32'd0 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  // One full transaction with dp_ready high; all sampling on the falling edge.
  task automatic xfer(input int sel, input string tag, input logic [31:0] addr,
                      input logic wr, input logic [31:0] data, input logic [7:0] size,
                      input logic [31:0] exp_data, input int exp_lat);
    int k;
    exp_q.push_back(exp_data);
    check({tag, "_pre_ready"}, o_ready(sel), 32'd1);
    drive(sel, 1'b1, addr, wr, data, size);
    set_dp_ready(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
    check({tag, "_busy_ready"}, o_ready(sel), 32'd0);
    wait_dpv(sel, k);
    check({tag, "_dp_valid"}, o_dpv(sel), 32'd1);
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_beat"}, o_data(sel), exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    check({tag, "_post_ready"}, o_ready(sel), 32'd1);
    check({tag, "_post_dpv"}, o_dpv(sel), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    reset = 1'b1;
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
    drive(4, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
    set_dp_ready(1, 1'b0);
    set_dp_ready(4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int s = 1; s <= 4; s += 3) begin
      check("rst_ready", o_ready(s), 32'd1);
      check("rst_dpv", o_dpv(s), 32'd0);
      check("rst_data", o_data(s), 32'h0);
      check("rst_state", o_state(s), 32'(ST_IDLE));
    end
    reset = 1'b0;
    @(negedge clk);

    // Reads, including range boundaries, on the LATENCY=1 instance.
    xfer(1, "rd0",     32'h0000_0000, 1'b0, 32'h0, 8'h0, 32'h0000_0400, 1);
    xfer(1, "rd_lo",   32'h0000_0003, 1'b0, 32'h0, 8'h0, 32'h0000_0400, 1);
    xfer(1, "rd_last", 32'h0000_003C, 1'b0, 32'h0, 8'h0, 32'h0000_0478, 1);
    xfer(1, "rd_past", 32'h0000_0040, 1'b0, 32'h0, 8'h0, 32'h0000_0040, 1);
    xfer(1, "rd_top",  32'hFFFF_FFFC, 1'b0, 32'h0, 8'h0, 32'h0000_0040, 1);

    // Writes of each size, ignored sizes and out-of-range writes.
    xfer(1, "wr_w",   32'h0000_0008, 1'b1, 32'hDEAD_BEEF, 8'd4,
         WR ? 32'hDEAD_BEEF : 32'h0000_0410, 1);
    xfer(1, "wr_b",   32'h0000_0008, 1'b1, 32'hAAAA_AA11, 8'd1,
         WR ? 32'hDEAD_BE11 : 32'h0000_0410, 1);
    xfer(1, "rd2",    32'h0000_0008, 1'b0, 32'h0, 8'h0,
         WR ? 32'hDEAD_BE11 : 32'h0000_0410, 1);
    xfer(1, "wr_h",   32'h0000_000A, 1'b1, 32'h5555_5678, 8'd2,
         WR ? 32'hDEAD_5678 : 32'h0000_0410, 1);
    xfer(1, "wr_sz3", 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 8'd3, 32'h0000_0400, 1);
    xfer(1, "rd0b",   32'h0000_0000, 1'b0, 32'h0, 8'h0, 32'h0000_0400, 1);
    xfer(1, "wr_oor", 32'h0000_0040, 1'b1, 32'h1234_5678, 8'd4, 32'h0000_0040, 1);
    xfer(1, "rd0c",   32'h0000_0000, 1'b0, 32'h0, 8'h0, 32'h0000_0400, 1);
    xfer(1, "rd2b",   32'h0000_0008, 1'b0, 32'h0, 8'h0,
         WR ? 32'hDEAD_5678 : 32'h0000_0410, 1);

    // LATENCY=4 with the data phase stalled and the request held valid.
    drive(4, 1'b1, 32'h0000_0004, 1'b0, 32'h0, 8'h0);
    set_dp_ready(4, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("stall_acc_state", o_state(4), 32'(ST_WAIT));
    wait_dpv(4, k);
    check("stall_latency", 32'(k), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("stall_dpv", o_dpv(4), 32'd1);
      check("stall_data", o_data(4), 32'h0000_0408);
      check("stall_ready", o_ready(4), 32'd0);
      if (i < 3) @(negedge clk);
    end
    set_dp_ready(4, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("hs_dpv", o_dpv(4), 32'd0);
    check("hs_ready", o_ready(4), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("reacc_state", o_state(4), 32'(ST_WAIT));
    check("reacc_ready", o_ready(4), 32'd0);
    drive(4, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
    wait_dpv(4, k);
    check("reacc_latency", 32'(k), 32'd4);
    check("reacc_data", o_data(4), 32'h0000_0408);
    @(posedge clk);
    @(negedge clk);
    check("reacc_idle", o_state(4), 32'(ST_IDLE));

    // Reset during WAIT after a write, and during RESP.
    xfer(4, "rst_wr1", 32'h0000_0004, 1'b1, 32'hCAFE_F00D, 8'd4,
         WR ? 32'hCAFE_F00D : 32'h0000_0408, 4);
    drive(4, 1'b1, 32'h0000_0004, 1'b1, 32'h0BAD_F00D, 8'd4);
    @(posedge clk);
    @(negedge clk);
    drive(4, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
    check("rstw_state_pre", o_state(4), 32'(ST_WAIT));
    reset = 1'b1;
    #1;
    check("rstw_state", o_state(4), 32'(ST_IDLE));
    check("rstw_ready", o_ready(4), 32'd1);
    check("rstw_dpv", o_dpv(4), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    xfer(4, "rstw_rd1", 32'h0000_0004, 1'b0, 32'h0, 8'h0, 32'h0000_0408, 4);

    drive(4, 1'b1, 32'h0000_0004, 1'b0, 32'h0, 8'h0);
    set_dp_ready(4, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(4, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
    wait_dpv(4, k);
    check("rstr_dpv_pre", o_dpv(4), 32'd1);
    reset = 1'b1;
    #1;
    check("rstr_dpv", o_dpv(4), 32'd0);
    check("rstr_data", o_data(4), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    xfer(4, "rstr_rd0", 32'h0000_0000, 1'b0, 32'h0, 8'h0, 32'h0000_0400, 4);
    xfer(1, "rst_rd2",  32'h0000_0008, 1'b0, 32'h0, 8'h0, 32'h0000_0410, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
